// File: rtl/neuron_accumulator.sv
// Neuron accumulator: sums sign-magnitude products onto a bias, then shifts,
// saturates to 16 bits and optionally applies ReLU before a valid/ready output.
module neuron_accumulator #(
  parameter int ACC_W   = 40,
  parameter int SHIFT   = 8,
  parameter int RELU_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  len,
  input  logic [31:0] bias,
  input  logic        prod_valid,
  input  logic [31:0] prod,
  output logic        prod_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        ovf,
  output logic        busy
);

  // state | meaning
  // IDLE  | waiting for start
  // ACC   | accepting products until the counter reaches zero
  // FIN   | shift, saturate and ReLU the sum into out_data
  // OUT   | out_valid held until out_ready
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] LIM_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] LIM_LO = ~LIM_HI;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [7:0]        r_cnt;
  logic        [15:0]       r_out_data;
  logic                     r_ovf;

  logic signed [ACC_W-1:0]  w_mag;
  logic signed [ACC_W-1:0]  w_term;
  logic signed [ACC_W-1:0]  w_shifted;
  logic        [15:0]       w_sat;
  logic        [15:0]       w_result;
  logic                     w_clamp_ovf;
  logic                     w_unused;

  // Bit 30 of the product carries no information.
  assign w_unused = prod[30];

  assign w_mag     = $signed({{(ACC_W-30){1'b0}}, prod[29:0]});
  assign w_term    = prod[31] ? -w_mag : w_mag;
  assign w_shifted = r_acc >>> SHIFT;

  always_comb begin
    w_sat       = w_shifted[15:0];
    w_clamp_ovf = 1'b0;
    if (w_shifted > LIM_HI) begin
      w_sat       = 16'h7FFF;
      w_clamp_ovf = 1'b1;
    end else if (w_shifted < LIM_LO) begin
      w_sat       = 16'h8000;
      w_clamp_ovf = 1'b1;
    end
    w_result = w_sat;
    if ((RELU_EN != 0) && w_sat[15]) begin
      w_result = 16'h0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = (len != 8'd0) ? S_ACC : S_FIN;
      S_ACC:  if (prod_valid && (r_cnt == 8'd1)) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_OUT;
      S_OUT:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc      <= '0;
      r_cnt      <= 8'd0;
      r_out_data <= 16'd0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= $signed({{(ACC_W-32){bias[31]}}, bias});
            r_cnt <= len;
          end
        end
        S_ACC: begin
          if (prod_valid) begin
            r_acc <= r_acc + w_term;
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_FIN: begin
          r_out_data <= w_result;
          r_ovf      <= w_clamp_ovf;
        end
        default: ;
      endcase
    end
  end

  assign prod_ready = (r_state == S_ACC);
  assign out_valid  = (r_state == S_OUT);
  assign busy       = (r_state != S_IDLE);
  assign out_data   = r_out_data;
  assign ovf        = r_ovf;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Bench for neuron_accumulator: directed cases plus randomized sums checked
// against an arithmetic reference, on ReLU-enabled and ReLU-disabled instances.
module tb_neuron_accumulator;

  typedef logic [31:0] q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [31:0] bias = 32'd0;
  logic        prod_valid = 1'b0;
  logic [31:0] prod = 32'd0;
  logic        out_ready = 1'b0;
  logic        prod_ready, out_valid, ovf, busy;
  logic [15:0] out_data;
  logic        prod_ready_n, out_valid_n, ovf_n, busy_n;
  logic [15:0] out_data_n;

  int checks = 0;
  int errors = 0;

  neuron_accumulator #(.ACC_W(40), .SHIFT(8), .RELU_EN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .ovf(ovf), .busy(busy)
  );

  neuron_accumulator #(.ACC_W(40), .SHIFT(8), .RELU_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias),
    .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready_n),
    .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
    .ovf(ovf_n), .busy(busy_n)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer sum, floor shift, clamp, optional ReLU.
  function automatic void model(input int n, input logic [31:0] b, input q_t p,
                                input bit relu, output logic [15:0] d, output logic ov);
    longint sum, s;
    sum = longint'($signed(b));
    for (int i = 0; i < n; i++) begin
      if (p[i][31]) sum = sum - longint'(p[i][29:0]);
      else          sum = sum + longint'(p[i][29:0]);
    end
    s  = sum >>> 8;
    ov = 1'b0;
    if (s > 32767)       begin s = 32767;  ov = 1'b1; end
    else if (s < -32768) begin s = -32768; ov = 1'b1; end
    if (relu && s < 0) s = 0;
    d = s[15:0];
  endfunction

  task automatic do_sum(input int n, input logic [31:0] b, input q_t prods,
                        input bit gaps, input int hold,
                        output logic [15:0] d1, output logic ov1,
                        output logic [15:0] d0, output logic ov0,
                        output int lat, output bit stable, output bit ignored);
    int idx, k, c;
    bit tog, acc_now;
    stable = 1; ignored = 1; lat = -1;
    d1 = 'x; ov1 = 'x; d0 = 'x; ov0 = 'x;
    start = 1'b1; len = n[7:0]; bias = b;
    @(posedge clk); #1;
    start = 1'b0; len = 8'($urandom); bias = $urandom;
    idx = 0; k = 0; tog = 1'b1;
    while (idx < n && k < 2000) begin
      prod_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      prod = prod_valid ? prods[idx] : $urandom;
      acc_now = prod_valid && prod_ready;
      @(posedge clk); #1;
      k++;
      if (acc_now) idx++;
    end
    prod_valid = 1'b0;
    c = 1;
    while (!out_valid && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    if (!out_valid) return;
    lat = c;
    d1 = out_data; ov1 = ovf; d0 = out_data_n; ov0 = ovf_n;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = h[0];
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_data !== d1 || ovf !== ov1 || prod_ready !== 1'b0)
        stable = 0;
    end
    out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    if (out_valid !== 1'b0 || busy !== 1'b0) ignored = 0;
    @(posedge clk); #1;
    if (busy !== 1'b0) ignored = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #13;
    checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++; if (prod_ready !== 1'b0) begin errors++; $display("FAIL reset_prod_ready: got %b want 0", prod_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    q_t p; logic [15:0] d1, d0; logic o1, o0; int lat; bit st, ig;
    p = '{32'h0000_0100, 32'h0000_0200, 32'h8000_0100};
    do_sum(3, 32'd0, p, 0, 0, d1, o1, d0, o0, lat, st, ig);
    checks++; if (d1 !== 16'h0002) begin errors++; $display("FAIL basic_data: got %h want 0002", d1); end
    checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", o1); end
    checks++; if (lat != 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", lat); end
    checks++; if (out_data !== 16'h0002) begin errors++; $display("FAIL basic_retain: got %h want 0002", out_data); end
    checks++; if (ig !== 1'b1) begin errors++; $display("FAIL basic_return_idle: got %b want 1", ig); end
  endtask

  task automatic test_relu;
    q_t p; logic [15:0] d1, d0; logic o1, o0; int lat; bit st, ig;
    p = '{32'h8000_1000};
    do_sum(1, 32'd0, p, 0, 0, d1, o1, d0, o0, lat, st, ig);
    checks++; if (d1 !== 16'h0000) begin errors++; $display("FAIL relu_on_data: got %h want 0000", d1); end
    checks++; if (o1 !== 1'b0) begin errors++; $display("FAIL relu_on_ovf: got %b want 0", o1); end
    checks++; if (d0 !== 16'hFFF0) begin errors++; $display("FAIL relu_off_data: got %h want fff0", d0); end
    checks++; if (o0 !== 1'b0) begin errors++; $display("FAIL relu_off_ovf: got %b want 0", o0); end
  endtask

  task automatic test_saturate;
    q_t p; logic [15:0] d1, d0; logic o1, o0; int lat; bit st, ig;
    p = '{32'h3FFF_FFFF, 32'h3FFF_FFFF};
    do_sum(2, 32'd0, p, 0, 0, d1, o1, d0, o0, lat, st, ig);
    checks++; if (d1 !== 16'h7FFF) begin errors++; $display("FAIL sat_data: got %h want 7fff", d1); end
    checks++; if (o1 !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", o1); end
    p = '{32'hBFFF_FFFF, 32'h8FFF_FFFF};
    do_sum(2, 32'd0, p, 0, 0, d1, o1, d0, o0, lat, st, ig);
    checks++; if (d0 !== 16'h8000 || o0 !== 1'b1) begin errors++; $display("FAIL sat_neg: got %h/%b want 8000/1", d0, o0); end
    checks++; if (d1 !== 16'h0000 || o1 !== 1'b1) begin errors++; $display("FAIL sat_neg_relu: got %h/%b want 0000/1", d1, o1); end
  endtask

  task automatic test_len0;
    q_t p; logic [15:0] d1, d0; logic o1, o0; int lat; bit st, ig;
    p = {};
    do_sum(0, 32'h0000_0500, p, 0, 0, d1, o1, d0, o0, lat, st, ig);
    checks++; if (lat != 2) begin errors++; $display("FAIL len0_latency: got %0d want 2", lat); end
    checks++; if (d1 !== 16'h0005) begin errors++; $display("FAIL len0_data: got %h want 0005", d1); end
  endtask

  task automatic test_stall;
    q_t p; logic [15:0] d1, d0, e1; logic o1, o0, eo; int lat; bit st, ig;
    p = '{32'h0001_2300, 32'h8000_4500, 32'h0000_0F00, 32'h8000_0100};
    model(4, 32'h0000_1000, p, 1, e1, eo);
    do_sum(4, 32'h0000_1000, p, 1, 5, d1, o1, d0, o0, lat, st, ig);
    checks++; if (d1 !== e1) begin errors++; $display("FAIL stall_data: got %h want %h", d1, e1); end
    checks++; if (lat != 2) begin errors++; $display("FAIL stall_latency: got %0d want 2", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_out_stable: got %b want 1", st); end
    checks++; if (ig !== 1'b1) begin errors++; $display("FAIL stall_start_ignored: got %b want 1", ig); end
  endtask

  task automatic test_reset_mid;
    q_t p; logic [15:0] d1, d0; logic o1, o0; int lat; bit st, ig; bit seen;
    start = 1'b1; len = 8'd4; bias = 32'h0000_7000;
    @(posedge clk); #1;
    start = 1'b0;
    prod_valid = 1'b1; prod = 32'h0000_4000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    prod_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (out_data !== 16'd0 || out_valid !== 1'b0 || ovf !== 1'b0 || prod_ready !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs: got d=%h v=%b o=%b r=%b b=%b want all 0", out_data, out_valid, ovf, prod_ready, busy); end
    #3 rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_output: got activity want none"); end
    p = '{32'h0000_0300};
    do_sum(1, 32'd0, p, 0, 0, d1, o1, d0, o0, lat, st, ig);
    checks++; if (d1 !== 16'h0003) begin errors++; $display("FAIL midrst_after: got %h want 0003", d1); end
  endtask

  task automatic test_random;
    q_t p; logic [15:0] d1, d0, e1, e0; logic o1, o0, eo1, eo0; int lat, n; bit st, ig;
    logic [31:0] b, v;
    for (int t = 0; t < 30; t++) begin
      n = (t % 5 == 0) ? $urandom_range(200, 255) : $urandom_range(0, 9);
      b = $urandom;
      if (t % 3 == 0) b = {{12{b[31]}}, b[19:0]};
      p = {};
      for (int i = 0; i < n; i++) begin
        v = $urandom;
        if (t % 2 == 0) v[29:20] = 10'd0;
        p.push_back(v);
      end
      model(n, b, p, 1, e1, eo1);
      model(n, b, p, 0, e0, eo0);
      do_sum(n, b, p, $urandom_range(0, 1), $urandom_range(0, 3), d1, o1, d0, o0, lat, st, ig);
      checks++; if (d1 !== e1 || o1 !== eo1) begin errors++; $display("FAIL rand_relu[%0d]: got %h/%b want %h/%b", t, d1, o1, e1, eo1); end
      checks++; if (d0 !== e0 || o0 !== eo0) begin errors++; $display("FAIL rand_norelu[%0d]: got %h/%b want %h/%b", t, d0, o0, e0, eo0); end
      checks++; if (lat != 2 || st !== 1'b1 || ig !== 1'b1) begin errors++; $display("FAIL rand_handshake[%0d]: got lat=%0d stable=%b idle=%b want 2/1/1", t, lat, st, ig); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturate();
    test_len0();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_accumulator.md
NEURON_ACCUMULATOR -- requirements
Module: neuron_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator width in bits (two's complement).
REQ-002 SHALL have parameter SHIFT, default 8, arithmetic right shift applied to the final sum before saturation.
REQ-003 SHALL have parameter RELU_EN, default 1, ReLU applied to the output when 1.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin a new neuron sum; sampled only in IDLE.
REQ-007 SHALL have port len  input  8  number of products to accumulate; latched on accepted start.
REQ-008 SHALL have port bias  input  32  two's complement bias; latched on accepted start.
REQ-009 SHALL have port prod_valid  input  1  a product is presented on prod.
REQ-010 SHALL have port prod  input  32  sign-magnitude product: bit 31 sign, bits [29:0] magnitude, bit 30 ignored.
REQ-011 SHALL have port prod_ready  output  1  block accepts prod this cycle.
REQ-012 SHALL have port out_data  output  16  signed result, registered.
REQ-013 SHALL have port out_valid  output  1  out_data valid; held until accepted.
REQ-014 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-015 SHALL have port ovf  output  1  saturation occurred for the current out_data.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACC, FIN, OUT.
REQ-018 IDLE: on start=1 SHALL latch len into a down-counter, set acc to sign-extended bias, go to ACC if len!=0, else FIN.
REQ-019 ACC: prod_ready SHALL be 1; a product is accepted on the cycle where prod_valid=1 and prod_ready=1.
REQ-020 On accept, SHALL add +magnitude (sign 0) or -magnitude (sign 1) to acc; -0 SHALL contribute 0.
REQ-021 On the accept that decrements the counter to 0, SHALL go to FIN; prod_ready SHALL be 0 in FIN, OUT and IDLE.
REQ-022 prod_valid gaps in ACC SHALL stall without changing acc or counter.
REQ-023 FIN (one cycle): SHALL compute s = acc >>> SHIFT (floor), clamp to [-32768, 32767], apply ReLU (negative -> 0) if RELU_EN, register into out_data, set ovf=1 iff clamping changed the value, go to OUT.
REQ-024 OUT: out_valid SHALL be 1 with out_data and ovf stable; on out_ready=1 SHALL go to IDLE with out_valid=0 the next cycle.
REQ-025 start SHALL be ignored in ACC, FIN, OUT; start in the same cycle that OUT completes SHALL be ignored (accepted no earlier than the next IDLE cycle).
REQ-026 ACC_W=40 SHALL hold 255 maximum-magnitude products plus any 32-bit bias without wrap; no wrap detection is required.
REQ-027 Latency: from the last product accept to out_valid=1 SHALL be exactly 2 cycles; len=0 gives out_valid 2 cycles after start.
REQ-028 out_data and ovf SHALL retain their value after leaving OUT until the next FIN.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, acc=0, counter=0, out_data=0, out_valid=0, ovf=0, prod_ready=0, busy=0.
REQ-030 Reset asserted mid-ACC or mid-OUT SHALL abandon the sum; no output SHALL be produced for it after release.

Verification
REQ-031 bias=0, len=3, prods +0x100, +0x200, -0x100 (0x80000100), out_ready=1 -> out_data=0x0002, ovf=0.
REQ-032 bias=0, len=1, prod -0x1000 (0x80001000), RELU_EN=1 -> out_data=0, ovf=0; with RELU_EN=0 -> out_data=0xFFF0.
REQ-033 bias=0, len=2, prods +0x3FFFFFFF twice -> out_data=0x7FFF, ovf=1.
REQ-034 len=0, bias=0x00000500 -> out_valid 2 cycles after start, out_data=0x0005.
REQ-035 len=4 with prod_valid toggled every other cycle and out_ready held 0 for 5 cycles in OUT -> correct sum, out_data stable, prod_ready=0 throughout OUT, start pulses ignored.
REQ-036 rst pulsed low after 2 of 4 products -> all outputs 0 immediately; new start with len=1, prod +0x300 -> out_data=0x0003.
